// File: rtl/video_pkg.sv
// Shared video definitions for the 4:2:2 packing path.
// Holds the default component width, the chroma-mode encodings and the pixel-pair
// phase enum used by ycbcr422_packer.
package video_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  // Chroma reduction modes for a horizontal pixel pair
  localparam int unsigned CHROMA_AVG = 0;  // rounded average of both pixels
  localparam int unsigned CHROMA_DEC = 1;  // keep the even pixel's chroma

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

endpackage

// File: rtl/chroma_avg2.sv
// Combinational chroma reduction for two horizontally adjacent samples.
// Ports:
//   iA    - even pixel sample
//   iB    - odd pixel sample
//   oAvg  - reduced sample: (iA+iB+1)>>1 when averaging, iA when decimating
module chroma_avg2
  import video_pkg::*;
#(
  parameter int unsigned DW          = DW_DEFAULT,
  parameter int unsigned CHROMA_MODE = CHROMA_AVG
) (
  input  logic [DW-1:0] iA,
  input  logic [DW-1:0] iB,
  output logic [DW-1:0] oAvg
);

  if (CHROMA_MODE == CHROMA_DEC) begin : g_dec
    logic unused_b;
    assign unused_b = ^iB;
    assign oAvg     = iA;
  end else begin : g_avg
    // One extra bit keeps the carry, so 255+255+1 still halves back to 255
    logic [DW:0] sum;
    assign sum  = {1'b0, iA} + {1'b0, iB} + {{DW{1'b0}}, 1'b1};
    assign oAvg = sum[DW:1];
  end

endmodule

// File: rtl/ycbcr422_packer.sv
// Packs a 4:4:4 Y/Cb/Cr pixel stream into a 4:2:2 word stream.
// Adjacent pixels are paired; each pair produces two words: (Y0, Cb) then (Y1, Cr).
// Ports:
//   iClk, iRst_n        - clock, synchronous active-low reset
//   iValid, iSol        - input pixel qualifier and start-of-line marker
//   iY, iCb, iCr        - input pixel components
//   oValid, oSol        - output word qualifier and first-word-of-line marker
//   oY, oC, oCsel       - output luma, chroma, chroma select (0 = Cb, 1 = Cr)
//   oOrphan             - one-cycle pulse when an unpaired even pixel is dropped
module ycbcr422_packer
  import video_pkg::*;
#(
  parameter int unsigned DW          = DW_DEFAULT,
  parameter int unsigned CHROMA_MODE = CHROMA_AVG
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iValid,
  input  logic          iSol,
  input  logic [DW-1:0] iY,
  input  logic [DW-1:0] iCb,
  input  logic [DW-1:0] iCr,
  output logic          oValid,
  output logic          oSol,
  output logic [DW-1:0] oY,
  output logic [DW-1:0] oC,
  output logic          oCsel,
  output logic          oOrphan
);

  phase_e        phase_q;

  // Pending even pixel
  logic [DW-1:0] y0_q;
  logic [DW-1:0] cb0_q;
  logic [DW-1:0] cr0_q;
  logic          sol0_q;

  // Odd word scheduled for the cycle after the even word
  logic          odd_pend_q;
  logic [DW-1:0] y1_q;
  logic [DW-1:0] cr1_q;

  // Registered outputs
  logic          valid_q;
  logic          sol_q;
  logic [DW-1:0] y_q;
  logic [DW-1:0] c_q;
  logic          csel_q;
  logic          orphan_q;

  logic [DW-1:0] cb_pair;
  logic [DW-1:0] cr_pair;

  chroma_avg2 #(
    .DW          (DW),
    .CHROMA_MODE (CHROMA_MODE)
  ) u_avg_cb (
    .iA   (cb0_q),
    .iB   (iCb),
    .oAvg (cb_pair)
  );

  chroma_avg2 #(
    .DW          (DW),
    .CHROMA_MODE (CHROMA_MODE)
  ) u_avg_cr (
    .iA   (cr0_q),
    .iB   (iCr),
    .oAvg (cr_pair)
  );

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      phase_q    <= PH_EVEN;
      y0_q       <= '0;
      cb0_q      <= '0;
      cr0_q      <= '0;
      sol0_q     <= 1'b0;
      odd_pend_q <= 1'b0;
      y1_q       <= '0;
      cr1_q      <= '0;
      valid_q    <= 1'b0;
      sol_q      <= 1'b0;
      y_q        <= '0;
      c_q        <= '0;
      csel_q     <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      sol_q    <= 1'b0;
      orphan_q <= 1'b0;

      if (odd_pend_q) begin
        valid_q    <= 1'b1;
        y_q        <= y1_q;
        c_q        <= cr1_q;
        csel_q     <= 1'b1;
        odd_pend_q <= 1'b0;
      end

      // A pair completes at least two edges after the previous one, so the even word
      // below never lands on the same edge as a scheduled odd word.
      if (iValid) begin
        if (iSol || (phase_q == PH_EVEN)) begin
          // Start-of-line restarts pairing; a waiting even pixel is discarded
          orphan_q <= iSol && (phase_q == PH_ODD);
          y0_q     <= iY;
          cb0_q    <= iCb;
          cr0_q    <= iCr;
          sol0_q   <= iSol;
          phase_q  <= PH_ODD;
        end else begin
          valid_q    <= 1'b1;
          sol_q      <= sol0_q;
          y_q        <= y0_q;
          c_q        <= cb_pair;
          csel_q     <= 1'b0;
          y1_q       <= iY;
          cr1_q      <= cr_pair;
          odd_pend_q <= 1'b1;
          phase_q    <= PH_EVEN;
        end
      end
    end
  end

  assign oValid  = valid_q;
  assign oSol    = sol_q;
  assign oY      = y_q;
  assign oC      = c_q;
  assign oCsel   = csel_q;
  assign oOrphan = orphan_q;

endmodule

// File: tb/tb_ycbcr422_packer.sv
// Directed bench for ycbcr422_packer. Two instances (averaging and decimating) see the
// same stimulus; a reference model pushes expected words, tagged with the cycle they
// must appear in, onto a scoreboard queue that is drained as the DUTs emit.
module tb_ycbcr422_packer;

  typedef struct {
    int         cyc;
    logic [7:0] y;
    logic [7:0] c_avg;
    logic [7:0] c_dec;
    logic       csel;
    logic       sol;
  } word_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       sol = 1'b0;
  logic [7:0] y = '0;
  logic [7:0] cb = '0;
  logic [7:0] cr = '0;

  logic       a_valid, a_sol, a_csel, a_orphan;
  logic [7:0] a_y, a_c;
  logic       d_valid, d_sol, d_csel, d_orphan;
  logic [7:0] d_y, d_c;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int         cyc = 0;
  logic       m_odd = 1'b0;
  logic [7:0] m_y0, m_cb0, m_cr0;
  logic       m_sol0;
  logic       exp_orph = 1'b0;
  logic       zero_chk = 1'b0;
  word_t      q[$];

  always #5 clk = ~clk;

  ycbcr422_packer #(
    .DW          (8),
    .CHROMA_MODE (0)
  ) u_dut_avg (
    .iClk    (clk),
    .iRst_n  (rst_n),
    .iValid  (valid),
    .iSol    (sol),
    .iY      (y),
    .iCb     (cb),
    .iCr     (cr),
    .oValid  (a_valid),
    .oSol    (a_sol),
    .oY      (a_y),
    .oC      (a_c),
    .oCsel   (a_csel),
    .oOrphan (a_orphan)
  );

  ycbcr422_packer #(
    .DW          (8),
    .CHROMA_MODE (1)
  ) u_dut_dec (
    .iClk    (clk),
    .iRst_n  (rst_n),
    .iValid  (valid),
    .iSol    (sol),
    .iY      (y),
    .iCb     (cb),
    .iCr     (cr),
    .oValid  (d_valid),
    .oSol    (d_sol),
    .oY      (d_y),
    .oC      (d_c),
    .oCsel   (d_csel),
    .oOrphan (d_orphan)
  );

  function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b) + 1;
    return 8'(s / 2);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Compare outputs produced by the previous edge against the model
  task automatic check_outputs();
    word_t w;
    if (cyc == 0) return;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      w = q.pop_front();
      chk("avg_valid", {7'd0, a_valid}, 8'd1);
      chk("avg_y", a_y, w.y);
      chk("avg_c", a_c, w.c_avg);
      chk("avg_csel", {7'd0, a_csel}, {7'd0, w.csel});
      chk("avg_sol", {7'd0, a_sol}, {7'd0, w.sol});
      chk("dec_valid", {7'd0, d_valid}, 8'd1);
      chk("dec_y", d_y, w.y);
      chk("dec_c", d_c, w.c_dec);
      chk("dec_csel", {7'd0, d_csel}, {7'd0, w.csel});
      chk("dec_sol", {7'd0, d_sol}, {7'd0, w.sol});
    end else begin
      chk("avg_idle_valid", {7'd0, a_valid}, 8'd0);
      chk("avg_idle_sol", {7'd0, a_sol}, 8'd0);
      chk("dec_idle_valid", {7'd0, d_valid}, 8'd0);
      chk("dec_idle_sol", {7'd0, d_sol}, 8'd0);
    end
    chk("avg_orphan", {7'd0, a_orphan}, {7'd0, exp_orph});
    chk("dec_orphan", {7'd0, d_orphan}, {7'd0, exp_orph});
    if (zero_chk) begin
      chk("avg_rst_y", a_y, 8'd0);
      chk("avg_rst_c", a_c, 8'd0);
      chk("avg_rst_csel", {7'd0, a_csel}, 8'd0);
      chk("dec_rst_y", d_y, 8'd0);
      chk("dec_rst_c", d_c, 8'd0);
      chk("dec_rst_csel", {7'd0, d_csel}, 8'd0);
    end
  endtask

  // One clock: check, drive at negedge, then advance the model on the rising edge
  task automatic step(input logic r, input logic v, input logic s,
                      input logic [7:0] py, input logic [7:0] pcb, input logic [7:0] pcr);
    word_t w;
    @(negedge clk);
    check_outputs();
    rst_n = r;
    valid = v;
    sol   = s;
    y     = py;
    cb    = pcb;
    cr    = pcr;
    @(posedge clk);
    cyc++;
    exp_orph = 1'b0;
    zero_chk = 1'b0;
    if (!r) begin
      m_odd    = 1'b0;
      zero_chk = 1'b1;
      q.delete();
    end else if (v) begin
      if (s || !m_odd) begin
        exp_orph = m_odd && s;
        m_y0     = py;
        m_cb0    = pcb;
        m_cr0    = pcr;
        m_sol0   = s;
        m_odd    = 1'b1;
      end else begin
        w.cyc = cyc;     w.y = m_y0; w.c_avg = avg2(m_cb0, pcb); w.c_dec = m_cb0;
        w.csel = 1'b0;   w.sol = m_sol0;
        q.push_back(w);
        w.cyc = cyc + 1; w.y = py;   w.c_avg = avg2(m_cr0, pcr); w.c_dec = m_cr0;
        w.csel = 1'b1;   w.sol = 1'b0;
        q.push_back(w);
        m_odd = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    // Reset held with toggling valid, then released with no input
    step(1'b0, 1'b1, 1'b1, 8'd1, 8'd2, 8'd3);
    step(1'b0, 1'b0, 1'b0, 8'd4, 8'd5, 8'd6);
    step(1'b0, 1'b1, 1'b0, 8'd7, 8'd8, 8'd9);
    idle(3);

    // Full-rate pair: expect (10,101,0,1) then (20,228,1,0)
    step(1'b1, 1'b1, 1'b1, 8'd10, 8'd100, 8'd200);
    step(1'b1, 1'b1, 1'b0, 8'd20, 8'd101, 8'd255);
    idle(2);

    // Gapped pair, then four back-to-back pixels forming a continuous burst
    step(1'b1, 1'b1, 1'b0, 8'd30, 8'd10, 8'd20);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 8'd31, 8'd13, 8'd24);
    step(1'b1, 1'b1, 1'b0, 8'd32, 8'd40, 8'd50);
    step(1'b1, 1'b1, 1'b0, 8'd33, 8'd43, 8'd55);
    step(1'b1, 1'b1, 1'b0, 8'd34, 8'd0, 8'd254);
    step(1'b1, 1'b1, 1'b0, 8'd35, 8'd1, 8'd255);
    idle(3);

    // Odd-length line, then new line starting at (50,60,70)
    step(1'b1, 1'b1, 1'b1, 8'd40, 8'd1, 8'd2);
    step(1'b1, 1'b1, 1'b0, 8'd41, 8'd3, 8'd4);
    step(1'b1, 1'b1, 1'b0, 8'd42, 8'd5, 8'd6);
    step(1'b1, 1'b1, 1'b1, 8'd50, 8'd60, 8'd70);
    step(1'b1, 1'b1, 1'b0, 8'd51, 8'd61, 8'd71);
    idle(3);

    // Rounding edge: Cb (255,255) and Cr (0,1)
    step(1'b1, 1'b1, 1'b1, 8'd1, 8'd255, 8'd0);
    step(1'b1, 1'b1, 1'b0, 8'd2, 8'd255, 8'd1);
    idle(2);

    // Sol while idle must be ignored; pairing continues mid-line
    step(1'b1, 1'b1, 1'b0, 8'd60, 8'd80, 8'd90);
    step(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 8'd61, 8'd82, 8'd93);
    idle(2);

    // Reset mid-pair: pending pixel dropped silently
    step(1'b1, 1'b1, 1'b1, 8'd7, 8'd8, 8'd9);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd90, 8'd91, 8'd92);
    step(1'b1, 1'b1, 1'b0, 8'd93, 8'd94, 8'd95);
    idle(4);

    // Every scheduled word must have been consumed
    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
